stepper_motion_ctrl: RTL and testbench

//  Multi-channel stepper motion controller.
//  - N_CH independent channels; each moves a motor from its current position to a target position.
//  - Step rate is programmable per channel. Drive mode is full, wave, half or off.
//  - Sits between the SPI register decode (cfg_* writes) and the pad coil outputs (4 coils per channel).

---
 rtl/stepper_pkg.sv | 36 +++
 rtl/stepper_motion_ctrl_if.sv | 12 +
 rtl/stepper_channel.sv | 149 ++++++++++++++
 rtl/stepper_motion_ctrl.sv | 51 +++++
 tb/tb_stepper_motion_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper motion controller:
// drive modes, register addresses, CTRL bit positions and the coil phase table.
package stepper_pkg;

   typedef enum logic [1:0] {
      MODE_FULL = 2'd0,
      MODE_WAVE = 2'd1,
      MODE_HALF = 2'd2,
      MODE_OFF  = 2'd3
   } mode_t;

   localparam logic [1:0] ADDR_TARGET = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_POS    = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int CTRL_MODE_LSB = 0;
   localparam int CTRL_STOP_BIT = 2;

   // Coils are {B-,A-,B+,A+}; odd entries energise two coils, even entries one.
   function automatic logic [3:0] phase_coils(input logic [2:0] idx);
      logic [3:0] coils;
      case (idx)
         3'd0:    coils = 4'b0001;
         3'd1:    coils = 4'b0011;
         3'd2:    coils = 4'b0010;
         3'd3:    coils = 4'b0110;
         3'd4:    coils = 4'b0100;
         3'd5:    coils = 4'b1100;
         3'd6:    coils = 4'b1000;
         default: coils = 4'b1001;
      endcase
      return coils;
   endfunction

endpackage

// File: rtl/stepper_motion_ctrl_if.sv
// Register-write bus from the SPI decode into the stepper motion controller.
interface stepper_motion_ctrl_if #(
   parameter int POS_W = 32
);
   logic             cfg_we;
   logic [2:0]       cfg_ch;
   logic [1:0]       cfg_addr;
   logic [POS_W-1:0] cfg_wdata;

   modport master (output cfg_we, cfg_ch, cfg_addr, cfg_wdata);
   modport slave  (input  cfg_we, cfg_ch, cfg_addr, cfg_wdata);
endinterface

// File: rtl/stepper_channel.sv
// One stepper channel: registers, IDLE/RUN FSM, rate counter and coil decode.
// STEPPER_EXT_STEP_EN adds external step/dir drive with a 2-flop synchroniser.
module stepper_channel
   import stepper_pkg::*;
#(
   parameter int POS_W = 32,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [POS_W-1:0] wr_data,
`ifdef STEPPER_EXT_STEP_EN
   input  logic             ext_en,
   input  logic             ext_step,
   input  logic             ext_dir,
`endif
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic [3:0]       coil
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   state_t           state_reg;
   mode_t            mode_reg;
   logic [POS_W-1:0] pos_reg, target_reg;
   logic [DIV_W-1:0] period_reg, cnt_reg;
   logic [2:0]       phase_reg;

   logic [POS_W-1:0] diff, pos_step, pos_next;
   logic [DIV_W-1:0] reload;
   logic [2:0]       inc, phase_step, phase_base, phase_aligned;
   logic             ext_mode, ext_fire, ext_fall, ext_dn;
   logic             run_step, do_step, step_dn;
   mode_t            wr_mode;

`ifdef STEPPER_EXT_STEP_EN
   // [0],[1] synchronise ext_step; [2] holds the previous synced level for edge detect.
   logic [2:0] sync_reg;
   logic       ext_en_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg   <= '0;
         ext_en_reg <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[1:0], ext_step};
         ext_en_reg <= ext_en;
      end
   end

   assign ext_mode = ext_en;
   assign ext_fire = ext_en && sync_reg[1] && !sync_reg[2] && (mode_reg != MODE_OFF);
   assign ext_fall = ext_en_reg && !ext_en;
   assign ext_dn   = !ext_dir;
`else
   assign ext_mode = 1'b0;
   assign ext_fire = 1'b0;
   assign ext_fall = 1'b0;
   assign ext_dn   = 1'b0;
`endif

   // Signed difference gives the shortest path around the position wrap.
   assign diff       = target_reg - pos_reg;
   assign reload     = (period_reg == '0) ? '0 : period_reg - DIV_ONE;
   assign inc        = (mode_reg == MODE_HALF) ? 3'd1 : 3'd2;
   assign run_step   = !ext_mode && (state_reg == ST_RUN) && (cnt_reg == '0) && (diff != '0);
   assign do_step    = run_step || ext_fire;
   assign step_dn    = ext_mode ? ext_dn : diff[POS_W-1];
   assign pos_step   = step_dn ? pos_reg - POS_ONE : pos_reg + POS_ONE;
   assign phase_step = step_dn ? phase_reg - inc : phase_reg + inc;
   assign pos_next   = do_step ? pos_step : pos_reg;
   assign phase_base = do_step ? phase_step : phase_reg;
   assign wr_mode    = mode_t'(wr_data[CTRL_MODE_LSB +: 2]);

   always_comb begin
      phase_aligned = phase_base;
      if (wr_mode == MODE_FULL)
         phase_aligned = {phase_base[2:1], 1'b1};
      else if (wr_mode == MODE_WAVE)
         phase_aligned = {phase_base[2:1], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         mode_reg   <= MODE_OFF;
         pos_reg    <= '0;
         target_reg <= '0;
         period_reg <= '0;
         cnt_reg    <= '0;
         phase_reg  <= '0;
      end else begin
         pos_reg   <= pos_next;
         phase_reg <= phase_base;

         case (state_reg)
            ST_IDLE: begin
               if (!ext_mode && (mode_reg != MODE_OFF) && (diff != '0)) begin
                  state_reg <= ST_RUN;
                  cnt_reg   <= reload;
               end
            end
            default: begin
               cnt_reg <= (cnt_reg == '0) ? reload : cnt_reg - DIV_ONE;
               if ((diff == '0) || (run_step && (pos_step == target_reg)))
                  state_reg <= ST_IDLE;
            end
         endcase

         if (ext_mode)
            state_reg <= ST_IDLE;
         if (ext_fall)
            target_reg <= pos_reg;

         // Register writes come last so they win over the step/FSM updates above.
         if (wr_en) begin
            case (wr_addr)
               ADDR_TARGET: target_reg <= wr_data;
               ADDR_PERIOD: period_reg <= wr_data[DIV_W-1:0];
               ADDR_POS: begin
                  if (state_reg == ST_IDLE)
                     pos_reg <= wr_data;
               end
               default: begin
                  mode_reg  <= wr_mode;
                  phase_reg <= phase_aligned;
                  if (wr_data[CTRL_STOP_BIT]) begin
                     target_reg <= pos_next;
                     state_reg  <= ST_IDLE;
                  end
                  if (wr_mode == MODE_OFF)
                     state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign pos  = pos_reg;
   assign busy = (state_reg == ST_RUN);
   assign coil = (mode_reg == MODE_OFF) ? 4'b0000 : phase_coils(phase_reg);

endmodule

// File: rtl/stepper_motion_ctrl.sv
// Multi-channel stepper motion controller top: cfg channel decode and output packing.
// STEPPER_EXT_STEP_EN adds per-channel ext_en/ext_step/ext_dir inputs.
module stepper_motion_ctrl
   import stepper_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int POS_W = 32,
   parameter int DIV_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   stepper_motion_ctrl_if.slave  cfg,
`ifdef STEPPER_EXT_STEP_EN
   input  logic [N_CH-1:0]       ext_en,
   input  logic [N_CH-1:0]       ext_step,
   input  logic [N_CH-1:0]       ext_dir,
`endif
   output logic [N_CH*POS_W-1:0] pos,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH*4-1:0]     coil_out
);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         // Channel numbers without an instance never match, so such writes drop.
         logic sel;
         assign sel = cfg.cfg_we && (cfg.cfg_ch == 3'(gi));

         stepper_channel #(
            .POS_W (POS_W),
            .DIV_W (DIV_W)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (sel),
            .wr_addr  (cfg.cfg_addr),
            .wr_data  (cfg.cfg_wdata),
`ifdef STEPPER_EXT_STEP_EN
            .ext_en   (ext_en[gi]),
            .ext_step (ext_step[gi]),
            .ext_dir  (ext_dir[gi]),
`endif
            .pos      (pos[gi*POS_W +: POS_W]),
            .busy     (busy[gi]),
            .coil     (coil_out[gi*4 +: 4])
         );
      end
   endgenerate

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Directed-vector bench for stepper_motion_ctrl; STEPPER_EXT_STEP_EN also runs the ext-step case.
module tb_stepper_motion_ctrl;
   import stepper_pkg::*;

   localparam int N_CH  = 2;
   localparam int POS_W = 32;
   localparam int DIV_W = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stepper_motion_ctrl_if #(.POS_W(POS_W)) cfg ();

   logic [N_CH*POS_W-1:0] pos;
   logic [N_CH-1:0]       busy;
   logic [N_CH*4-1:0]     coil_out;
`ifdef STEPPER_EXT_STEP_EN
   logic [N_CH-1:0]       ext_en   = '0;
   logic [N_CH-1:0]       ext_step = '0;
   logic [N_CH-1:0]       ext_dir  = '0;
`endif

   stepper_motion_ctrl #(
      .N_CH  (N_CH),
      .POS_W (POS_W),
      .DIV_W (DIV_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg      (cfg),
`ifdef STEPPER_EXT_STEP_EN
      .ext_en   (ext_en),
      .ext_step (ext_step),
      .ext_dir  (ext_dir),
`endif
      .pos      (pos),
      .busy     (busy),
      .coil_out (coil_out)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic logic [31:0] pos_of(input int c);
      return pos[c*POS_W +: POS_W];
   endfunction

   function automatic logic [31:0] coil_of(input int c);
      return {28'd0, coil_out[c*4 +: 4]};
   endfunction

   function automatic logic [31:0] busy_of(input int c);
      return {31'd0, busy[c]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [1:0] addr, input logic [31:0] data);
      cfg.cfg_we    = 1'b1;
      cfg.cfg_ch    = ch;
      cfg.cfg_addr  = addr;
      cfg.cfg_wdata = data;
      tick();
      cfg.cfg_we    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Waits out one step interval: position must hold until the final edge, then move.
   task automatic step_wait(input int c, input int per, input logic [31:0] prev,
                            input logic [31:0] nxt, input string tag);
      repeat (per - 1) tick();
      check({tag, "_hold"}, pos_of(c), prev);
      tick();
      check(tag, pos_of(c), nxt);
   endtask

   logic [3:0] t1_coils [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
   logic [3:0] t2_coils [3] = '{4'b1001, 4'b1000, 4'b1100};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg.cfg_we    = 1'b0;
      cfg.cfg_ch    = '0;
      cfg.cfg_addr  = '0;
      cfg.cfg_wdata = '0;

      // Reset state
      do_reset();
      check("rst_pos0", pos_of(0), 32'd0);
      check("rst_pos1", pos_of(1), 32'd0);
      check("rst_busy", {30'd0, busy}, 32'd0);
      check("rst_coil", {24'd0, coil_out}, 32'd0);

      // 1: FULL, target 4, period 10
      wr(3'd0, ADDR_CTRL, 32'd0);
      check("t1_coil_init", coil_of(0), 32'b0011);
      wr(3'd0, ADDR_PERIOD, 32'd10);
      wr(3'd0, ADDR_TARGET, 32'd4);
      check("t1_busy_wr", busy_of(0), 32'd0);
      tick();
      check("t1_busy_run", busy_of(0), 32'd1);
      for (int s = 1; s <= 4; s++) begin
         if (s == 4) check("t1_busy_last", busy_of(0), 32'd1);
         step_wait(0, 10, 32'(s - 1), 32'(s), $sformatf("t1_pos%0d", s));
         check($sformatf("t1_coil%0d", s), coil_of(0), {28'd0, t1_coils[s-1]});
      end
      check("t1_busy_done", busy_of(0), 32'd0);

      // 2: HALF, target -3, period 0 -> one step per clock
      do_reset();
      wr(3'd0, ADDR_CTRL, 32'd2);
      check("t2_coil_init", coil_of(0), 32'b0001);
      wr(3'd0, ADDR_PERIOD, 32'd0);
      wr(3'd0, ADDR_TARGET, 32'hFFFF_FFFD);
      tick();
      check("t2_busy_run", busy_of(0), 32'd1);
      for (int s = 1; s <= 3; s++) begin
         step_wait(0, 1, 32'(-(s - 1)), 32'(-s), $sformatf("t2_pos%0d", s));
         check($sformatf("t2_coil%0d", s), coil_of(0), {28'd0, t2_coils[s-1]});
      end
      check("t2_busy_done", busy_of(0), 32'd0);

      // 3: move across the signed wrap
      wr(3'd0, ADDR_CTRL, 32'd3);
      check("t3_coil_off", coil_of(0), 32'd0);
      wr(3'd0, ADDR_POS, 32'h7FFF_FFFE);
      wr(3'd0, ADDR_TARGET, 32'h8000_0001);
      check("t3_pos_set", pos_of(0), 32'h7FFF_FFFE);
      check("t3_idle_off", busy_of(0), 32'd0);
      wr(3'd0, ADDR_CTRL, 32'd2);
      tick();
      check("t3_busy1", busy_of(0), 32'd1);
      step_wait(0, 1, 32'h7FFF_FFFE, 32'h7FFF_FFFF, "t3_pos1");
      check("t3_busy2", busy_of(0), 32'd1);
      step_wait(0, 1, 32'h7FFF_FFFF, 32'h8000_0000, "t3_pos2");
      check("t3_busy3", busy_of(0), 32'd1);
      step_wait(0, 1, 32'h8000_0000, 32'h8000_0001, "t3_pos3");
      check("t3_busy_done", busy_of(0), 32'd0);

      // 4: ch1 runs toward 1000, stopped after 5 steps
      wr(3'd1, ADDR_CTRL, 32'd0);
      wr(3'd1, ADDR_PERIOD, 32'd4);
      wr(3'd1, ADDR_TARGET, 32'd1000);
      tick();
      check("t4_busy_run", busy_of(1), 32'd1);
      for (int s = 1; s <= 5; s++)
         step_wait(1, 4, 32'(s - 1), 32'(s), $sformatf("t4_pos%0d", s));
      wr(3'd1, ADDR_CTRL, 32'b100);
      check("t4_busy_stop", busy_of(1), 32'd0);
      check("t4_pos_stop", pos_of(1), 32'd5);
      repeat (10) tick();
      check("t4_pos_held", pos_of(1), 32'd5);
      check("t4_busy_held", busy_of(1), 32'd0);
      check("t4_ch0_pos", pos_of(0), 32'h8000_0001);
      check("t4_ch0_busy", busy_of(0), 32'd0);

      // 5: POS ignored in RUN, reverse on retarget, out-of-range channel
      wr(3'd1, ADDR_TARGET, 32'd10);
      tick();
      check("t5_busy_run", busy_of(1), 32'd1);
      step_wait(1, 4, 32'd5, 32'd6, "t5_pos_up");
      wr(3'd1, ADDR_POS, 32'd100);
      check("t5_pos_ignored", pos_of(1), 32'd6);
      wr(3'd1, ADDR_TARGET, 32'd2);
      tick();
      check("t5_pos_pre_rev", pos_of(1), 32'd6);
      tick();
      check("t5_pos_rev", pos_of(1), 32'd5);
      step_wait(1, 4, 32'd5, 32'd4, "t5_pos4");
      step_wait(1, 4, 32'd4, 32'd3, "t5_pos3");
      step_wait(1, 4, 32'd3, 32'd2, "t5_pos2");
      check("t5_busy_done", busy_of(1), 32'd0);
      check("t5_coil", coil_of(1), 32'b1100);
      wr(3'd2, ADDR_TARGET, 32'd50);
      wr(3'd2, ADDR_POS, 32'd77);
      repeat (3) tick();
      check("t5_badch_busy", {30'd0, busy}, 32'd0);
      check("t5_badch_pos1", pos_of(1), 32'd2);
      check("t5_badch_pos0", pos_of(0), 32'h8000_0001);

`ifdef STEPPER_EXT_STEP_EN
      // 6: external step drive, dir=0, three pulses
      do_reset();
      wr(3'd0, ADDR_CTRL, 32'd2);
      ext_dir[0] = 1'b0;
      ext_en[0]  = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         ext_step[0] = 1'b1;
         repeat (2) tick();
         check($sformatf("t6_hold%0d", k), pos_of(0), 32'(-(k - 1)));
         ext_step[0] = 1'b0;
         tick();
         check($sformatf("t6_pos%0d", k), pos_of(0), 32'(-k));
         check($sformatf("t6_busy%0d", k), busy_of(0), 32'd0);
         repeat (2) tick();
      end
      check("t6_coil", coil_of(0), 32'b1100);
      ext_en[0] = 1'b0;
      repeat (5) tick();
      check("t6_pos_rearm", pos_of(0), 32'hFFFF_FFFD);
      check("t6_busy_rearm", busy_of(0), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
